// File: rtl/prog_byte_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Holds the FSM encoding, abort codes and frame byte layout.
package prog_byte_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHK   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
    localparam logic [1:0] ERR_COUNT    = 2'd1;
    localparam logic [1:0] ERR_NIBBLE   = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;

    localparam int BYTE_W = 8;
    localparam int NIB_W  = 4;

    // States in which a frame byte can be taken from the channel.
    function automatic logic is_rx_state(input state_t s);
        return (s == ST_HDR) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHK);
    endfunction

    // States from which a start pulse opens a new frame.
    function automatic logic is_restart_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/prog_byte_loader_load_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and
// flags the final cycle of the allowed window.
module load_timeout
    import prog_byte_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != LAST)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expire = en && (count_reg == LAST);

endmodule

// File: rtl/prog_byte_loader.sv
// Loads a framed program (count, instruction byte pairs, XOR checksum) from a
// valid/ready byte channel into the program-memory load port.
module prog_byte_loader
    import prog_byte_loader_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int INSTR_W     = 12,
    parameter int MAX_WORDS   = 10,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               pmem_le,
    output logic [ADDR_W-1:0]  pmem_la,
    output logic [INSTR_W-1:0] pmem_li,
    output logic               busy,
    output logic               load_done,
    output logic               load_err,
    output logic [1:0]         err_code,
    output logic [ADDR_W-1:0]  word_count
);

    localparam logic [BYTE_W-1:0] MAX_COUNT = BYTE_W'(MAX_WORDS);

    state_t              state_reg;
    logic [BYTE_W-1:0]   n_reg;
    logic [BYTE_W-1:0]   chk_reg;
    logic [NIB_W-1:0]    hi_reg;
    logic [ADDR_W-1:0]   idx_reg;
    logic [ADDR_W-1:0]   word_count_reg;
    logic                pmem_le_reg;
    logic [ADDR_W-1:0]   pmem_la_reg;
    logic [INSTR_W-1:0]  pmem_li_reg;
    logic [1:0]          err_code_reg;

    logic xfer;
    logic restart;
    logic timer_expire;

    assign in_ready = is_rx_state(state_reg);
    assign xfer     = in_valid && in_ready;
    assign restart  = start && is_restart_state(state_reg);

    load_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr   (xfer || restart),
        .en    (in_ready),
        .expire(timer_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            n_reg          <= '0;
            chk_reg        <= '0;
            hi_reg         <= '0;
            idx_reg        <= '0;
            word_count_reg <= '0;
            pmem_le_reg    <= 1'b0;
            pmem_la_reg    <= '0;
            pmem_li_reg    <= '0;
            err_code_reg   <= ERR_TIMEOUT;
        end else begin
            pmem_le_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_reg      <= ST_HDR;
                        n_reg          <= '0;
                        chk_reg        <= '0;
                        idx_reg        <= '0;
                        word_count_reg <= '0;
                        err_code_reg   <= ERR_TIMEOUT;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        if ((in_data == '0) || (in_data > MAX_COUNT)) begin
                            state_reg    <= ST_ERR;
                            err_code_reg <= ERR_COUNT;
                        end else begin
                            n_reg     <= in_data;
                            chk_reg   <= chk_reg ^ in_data;
                            state_reg <= ST_HI;
                        end
                    end else if (timer_expire) begin
                        state_reg    <= ST_ERR;
                        err_code_reg <= ERR_TIMEOUT;
                    end
                end
                ST_HI: begin
                    if (xfer) begin
                        // Only 12-bit instructions exist, so the upper nibble must be clear.
                        if (in_data[7:4] != '0) begin
                            state_reg    <= ST_ERR;
                            err_code_reg <= ERR_NIBBLE;
                        end else begin
                            hi_reg    <= in_data[3:0];
                            chk_reg   <= chk_reg ^ in_data;
                            state_reg <= ST_LO;
                        end
                    end else if (timer_expire) begin
                        state_reg    <= ST_ERR;
                        err_code_reg <= ERR_TIMEOUT;
                    end
                end
                ST_LO: begin
                    if (xfer) begin
                        chk_reg     <= chk_reg ^ in_data;
                        pmem_le_reg <= 1'b1;
                        pmem_la_reg <= idx_reg;
                        pmem_li_reg <= INSTR_W'({hi_reg, in_data});
                        state_reg   <= ST_WRITE;
                    end else if (timer_expire) begin
                        state_reg    <= ST_ERR;
                        err_code_reg <= ERR_TIMEOUT;
                    end
                end
                ST_WRITE: begin
                    idx_reg        <= idx_reg + 1'b1;
                    word_count_reg <= word_count_reg + 1'b1;
                    if (idx_reg == ADDR_W'(n_reg - 8'd1)) begin
                        state_reg <= ST_CHK;
                    end else begin
                        state_reg <= ST_HI;
                    end
                end
                ST_CHK: begin
                    if (xfer) begin
                        if (in_data == chk_reg) begin
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg    <= ST_ERR;
                            err_code_reg <= ERR_CHECKSUM;
                        end
                    end else if (timer_expire) begin
                        state_reg    <= ST_ERR;
                        err_code_reg <= ERR_TIMEOUT;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign pmem_le    = pmem_le_reg;
    assign pmem_la    = pmem_la_reg;
    assign pmem_li    = pmem_li_reg;
    assign busy       = in_ready || (state_reg == ST_WRITE);
    assign load_done  = (state_reg == ST_DONE);
    assign load_err   = (state_reg == ST_ERR);
    assign err_code   = err_code_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_prog_byte_loader.sv
// Bench for prog_byte_loader: frame-position reference model compared every cycle,
// directed frames with literal expectations, then randomized frames.
module tb_prog_byte_loader;

    localparam int ADDR_W    = 8;
    localparam int INSTR_W   = 12;
    localparam int MAX_WORDS = 10;
    localparam int TO_CYC    = 16;

    localparam int MD_IDLE = 0;
    localparam int MD_RX   = 1;
    localparam int MD_WR   = 2;
    localparam int MD_DONE = 3;
    localparam int MD_ERR  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic [7:0]         in_data = 8'h00;
    logic               in_ready;
    logic               pmem_le;
    logic [ADDR_W-1:0]  pmem_la;
    logic [INSTR_W-1:0] pmem_li;
    logic               busy;
    logic               load_done;
    logic               load_err;
    logic [1:0]         err_code;
    logic [ADDR_W-1:0]  word_count;

    prog_byte_loader #(
        .ADDR_W     (ADDR_W),
        .INSTR_W    (INSTR_W),
        .MAX_WORDS  (MAX_WORDS),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .pmem_le   (pmem_le),
        .pmem_la   (pmem_la),
        .pmem_li   (pmem_li),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err),
        .err_code  (err_code),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: tracks position within the frame rather than FSM states.
    int         m_mode = MD_IDLE;
    int         m_pos = 0;
    int         m_n = 0;
    int         m_timer = 0;
    int         m_words = 0;
    logic [7:0] m_chk = 8'h00;
    logic [3:0] m_hi = 4'h0;
    logic [1:0] m_err = 2'd0;
    logic       m_le = 1'b0;
    logic [7:0] m_la = 8'h00;
    logic [11:0] m_li = 12'h000;
    bit         model_live = 0;

    task automatic model_abort(input logic [1:0] code);
        m_mode = MD_ERR;
        m_err  = code;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_timer = 0;
        if (m_pos == 0) begin
            if (b == 8'd0 || b > 8'(MAX_WORDS)) begin
                model_abort(2'd1);
            end else begin
                m_n = int'(b);
                m_chk ^= b;
                m_pos++;
            end
        end else if (m_pos == 2 * m_n + 1) begin
            if (b == m_chk) m_mode = MD_DONE;
            else model_abort(2'd3);
        end else if (m_pos % 2 == 1) begin
            if (b[7:4] != 4'h0) begin
                model_abort(2'd2);
            end else begin
                m_hi = b[3:0];
                m_chk ^= b;
                m_pos++;
            end
        end else begin
            m_chk ^= b;
            m_le = 1'b1;
            m_la = 8'(m_words);
            m_li = {m_hi, b};
            m_mode = MD_WR;
            m_pos++;
        end
    endtask

    task automatic model_step();
        if (!rst) begin
            m_mode = MD_IDLE; m_pos = 0; m_n = 0; m_timer = 0; m_words = 0;
            m_chk = 8'h00; m_err = 2'd0; m_le = 1'b0; m_la = 8'h00; m_li = 12'h000;
            return;
        end
        m_le = 1'b0;
        case (m_mode)
            MD_IDLE, MD_DONE, MD_ERR: begin
                if (start) begin
                    m_mode = MD_RX; m_pos = 0; m_chk = 8'h00;
                    m_words = 0; m_timer = 0; m_err = 2'd0;
                end
            end
            MD_RX: begin
                if (in_valid) model_byte(in_data);
                else if (m_timer == TO_CYC - 1) model_abort(2'd0);
                else m_timer++;
            end
            default: begin
                m_words++;
                m_mode = MD_RX;
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            model_live = 1;
        end
    end

    logic [19:0] wr_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                check("in_ready",   32'(in_ready),   32'(m_mode == MD_RX));
                check("busy",       32'(busy),       32'(m_mode == MD_RX || m_mode == MD_WR));
                check("load_done",  32'(load_done),  32'(m_mode == MD_DONE));
                check("load_err",   32'(load_err),   32'(m_mode == MD_ERR));
                check("err_code",   32'(err_code),   (m_mode == MD_ERR) ? 32'(m_err) : 32'd0);
                check("word_count", 32'(word_count), 32'(m_words));
                check("pmem_le",    32'(pmem_le),    32'(m_le));
                check("pmem_la",    32'(pmem_la),    32'(m_la));
                check("pmem_li",    32'(pmem_li),    32'(m_li));
                if (pmem_le === 1'b1) wr_log.push_back({pmem_la, pmem_li});
            end
        end
    end

    logic [7:0] frame[$];

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int   waited;
        logic r;
        ok = 0;
        for (int i = 0; i < gap; i++) begin
            start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            start = 1'b0;
        end
        if (busy !== 1'b1) return;
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        forever begin
            r = in_ready;
            @(negedge clk);
            if (r === 1'b1) begin
                ok = 1;
                break;
            end
            waited++;
            if (waited > 40) begin
                check("byte_accept_bound", 32'(waited), 32'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int maxgap);
        bit ok;
        foreach (frame[i]) begin
            send_byte(frame[i], $urandom_range(0, maxgap), ok);
            if (!ok) break;
        end
    endtask

    task automatic set_frame1(input logic [7:0] c);
        frame = {8'h03, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF, c};
    endtask

    logic [19:0] t1_exp[3];
    int          t0;
    int          waited;
    bit          ok;

    initial begin
        t1_exp[0] = 20'h00ABC;
        t1_exp[1] = 20'h01123;
        t1_exp[2] = 20'h02FFF;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_pmem_li", 32'(pmem_li), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: good frame, back-to-back bytes
        wr_log.delete();
        pulse_start();
        t0 = cyc;
        set_frame1(8'h67);
        send_frame(0);
        check("t1_latency", 32'(cyc - t0), 32'd11);
        check("t1_nwrites", 32'(wr_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < wr_log.size(); i++)
            check("t1_write", 32'(wr_log[i]), 32'(t1_exp[i]));
        check("t1_done", 32'(load_done), 32'd1);
        check("t1_err", 32'(load_err), 32'd0);
        check("t1_wc", 32'(word_count), 32'd3);

        // 2: count over the limit, then a good frame
        wr_log.delete();
        pulse_start();
        frame = {8'h0B, 8'h01, 8'h02};
        send_frame(0);
        check("t2_nwrites", 32'(wr_log.size()), 32'd0);
        check("t2_err", 32'(load_err), 32'd1);
        check("t2_code", 32'(err_code), 32'd1);
        pulse_start();
        set_frame1(8'h67);
        send_frame(0);
        check("t2_done", 32'(load_done), 32'd1);

        // 3: bad high nibble
        pulse_start();
        frame = {8'h02, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        check("t3_err", 32'(load_err), 32'd1);
        check("t3_code", 32'(err_code), 32'd2);
        check("t3_wc", 32'(word_count), 32'd0);

        // 4: wrong checksum after all writes
        wr_log.delete();
        pulse_start();
        set_frame1(8'h00);
        send_frame(0);
        check("t4_nwrites", 32'(wr_log.size()), 32'd3);
        check("t4_err", 32'(load_err), 32'd1);
        check("t4_code", 32'(err_code), 32'd3);
        check("t4_done", 32'(load_done), 32'd0);

        // 5: inter-byte timeout
        pulse_start();
        send_byte(8'h02, 0, ok);
        waited = 0;
        while (load_err !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("t5_timeout_cycles", 32'(waited), 32'd16);
        check("t5_code", 32'(err_code), 32'd0);

        // 6: reset after the second word, then a clean reload
        pulse_start();
        frame = {8'h03, 8'h0A, 8'hBC, 8'h01, 8'h23};
        send_frame(0);
        @(negedge clk);
        check("t6_wc_before_rst", 32'(word_count), 32'd2);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_wc", 32'(word_count), 32'd0);
        check("t6_rst_la", 32'(pmem_la), 32'd0);
        check("t6_rst_li", 32'(pmem_li), 32'd0);
        check("t6_rst_le", 32'(pmem_le), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        wr_log.delete();
        pulse_start();
        set_frame1(8'h67);
        send_frame(0);
        check("t6_done", 32'(load_done), 32'd1);
        check("t6_nwrites", 32'(wr_log.size()), 32'd3);

        // Randomized frames with occasional faults, gaps and stray starts
        for (int f = 0; f < 40; f++) begin
            int         n;
            int         real_n;
            logic [7:0] c;
            logic [7:0] b;
            int         maxgap;
            n = $urandom_range(1, MAX_WORDS);
            if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(11, 15);
            real_n = (n >= 1 && n <= MAX_WORDS) ? n : 2;
            frame = {};
            frame.push_back(8'(n));
            c = 8'(n);
            for (int k = 0; k < real_n; k++) begin
                b = 8'($urandom_range(0, 15));
                if ($urandom_range(0, 19) == 0) b[7:4] = 4'($urandom_range(1, 15));
                frame.push_back(b);
                c ^= b;
                b = 8'($urandom_range(0, 255));
                frame.push_back(b);
                c ^= b;
            end
            if ($urandom_range(0, 7) == 0) c = ~c;
            frame.push_back(c);
            maxgap = ($urandom_range(0, 24) == 0) ? 20 : 4;
            pulse_start();
            send_frame(maxgap);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
